// File: rtl/bram_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo_fwft
// Brief    : Synchronous FIFO on an inferred simple dual-port block RAM with
//            a show-ahead output stage, occupancy count, almost-full and
//            almost-empty flags, and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module bram_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

    // Storage array; intentionally without reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // wr_ptr_q : next address to write.
    // rd_ptr_q : next address to fetch into the show-ahead stage.
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  valid_q,  valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_avail;
    logic w_fetch;

    // Acceptance decisions, fetch decision and next-state values.
    always_comb begin
        w_full   = (count_q == c_DEPTH);
        // A push is judged only against the current full status, so a push
        // to a full FIFO is dropped even when a pop is accepted alongside it.
        w_push   = wr_en & ~w_full;
        w_pop    = rd_en & valid_q;
        // Words sitting in memory that are not yet in the output stage. A word
        // written on this edge is not counted, which guarantees the fetch never
        // reads the address being written in the same cycle.
        w_avail  = (count_q > {{ADDR_WIDTH{1'b0}}, valid_q});
        w_fetch  = (~valid_q | w_pop) & w_avail;

        wr_ptr_d = w_push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_fetch ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end

        valid_d = valid_q;
        if (w_fetch) begin
            valid_d = 1'b1;
        end else if (w_pop) begin
            valid_d = 1'b0;
        end

        overflow_d  = overflow_q  | (wr_en & w_full);
        underflow_d = underflow_q | (rd_en & ~valid_q);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Synchronous write port of the RAM.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Registered read port of the RAM; this register is the show-ahead stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (w_fetch) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign rd_data      = rd_data_q;
    assign empty        = ~valid_q;
    assign full         = w_full;
    assign almost_full  = (count_q >= c_AF);
    assign almost_empty = (count_q <= c_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire
